// File: rtl/mux_wb_pipe.sv
// rtl/mux_wb_pipe.sv - write-back source selector with a 2-entry skid buffer
// Picks one of NUM_SRC sources or CONST_VAL and carries rd plus an illegal-select flag.
module mux_wb_pipe #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 8,
  parameter int SEL_W     = 4,
  parameter int RD_W      = 5,
  parameter int CONST_VAL = 227
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [RD_W-1:0]          rd_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [RD_W-1:0]          out_rd,
  output logic                     out_err,
  output logic                     sel_err,
  input  logic                     err_clr
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

  logic [1:0]       state;
  logic [WIDTH-1:0] dec_data;
  logic             dec_err;
  logic [WIDTH-1:0] skid_data;
  logic [RD_W-1:0]  skid_rd;
  logic             skid_err;
  logic             acc;
  logic             move;

  // Every select value maps to something: source, trap constant, or zero with err.
  always_comb begin
    dec_data = '0;
    dec_err  = 1'b0;
    if (int'(sel) == NUM_SRC) begin
      dec_data = CONST_W;
    end else if (int'(sel) > NUM_SRC) begin
      dec_err = 1'b1;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (int'(sel) == k) dec_data = src_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is held low in reset so nothing is taken before the buffer is cleared.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL) & reset_n;
  assign acc       = in_valid & in_ready;
  assign move      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      out_rd    <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_rd   <= '0;
      skid_err  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (acc && dec_err) sel_err <= 1'b1;
      else if (err_clr)   sel_err <= 1'b0;

      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_data <= dec_data;
            out_rd   <= rd_in;
            out_err  <= dec_err;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && move) begin
            out_data <= dec_data;
            out_rd   <= rd_in;
            out_err  <= dec_err;
          end else if (acc) begin
            skid_data <= dec_data;
            skid_rd   <= rd_in;
            skid_err  <= dec_err;
            state     <= ST_FULL;
          end else if (move) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (move) begin
            out_data <= skid_data;
            out_rd   <= skid_rd;
            out_err  <= skid_err;
            state    <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_wb_pipe.sv
// tb/tb_mux_wb_pipe.sv - scoreboard bench for mux_wb_pipe
// Directed cases followed by a randomised handshake run against a select-rule model.
module tb_mux_wb_pipe;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 4;
  localparam int RD_W    = 5;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [RD_W-1:0]  rd;
    logic             err;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_bus;
  logic [RD_W-1:0]          rd_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [RD_W-1:0]          out_rd;
  logic                     out_err;
  logic                     sel_err;
  logic                     err_clr;

  logic [WIDTH-1:0] src_w [NUM_SRC];
  beat_t            expq[$];
  logic             exp_sel_err = 1'b0;
  int               checks = 0;
  int               errors = 0;
  int               pops = 0;

  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic [RD_W-1:0]  hold_rd;
  logic             hold_e;
  beat_t            mb;

  mux_wb_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src_bus(src_bus), .rd_in(rd_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_err(out_err), .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t model(input logic [SEL_W-1:0] s, input logic [RD_W-1:0] r);
    beat_t b;
    b.rd = r;
    b.err = 1'b0;
    b.data = '0;
    if (s < NUM_SRC) b.data = src_w[s];
    else if (s == NUM_SRC) b.data = 227;
    else b.err = 1'b1;
    return b;
  endfunction

  task automatic pack_srcs();
    for (int k = 0; k < NUM_SRC; k++) src_bus[k*WIDTH +: WIDTH] = src_w[k];
  endtask

  task automatic rand_srcs();
    for (int k = 0; k < NUM_SRC; k++) src_w[k] = $urandom;
    pack_srcs();
  endtask

  // One clock: record any accept at the falling edge, then advance past the rising edge.
  task automatic step(output logic acc);
    beat_t b;
    logic nxt;
    @(negedge clk);
    acc = reset_n && in_valid && in_ready;
    nxt = exp_sel_err;
    if (acc) begin
      b = model(sel, rd_in);
      expq.push_back(b);
      if (b.err) nxt = 1'b1;
      else if (err_clr) nxt = 1'b0;
    end else if (err_clr) begin
      nxt = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      exp_sel_err = 1'b0;
      expq.delete();
    end else begin
      exp_sel_err = nxt;
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic offer(input logic [SEL_W-1:0] s, input logic [RD_W-1:0] r);
    logic a;
    int   n;
    in_valid = 1'b1;
    sel = s;
    rd_in = r;
    n = 0;
    a = 1'b0;
    while (!a && n < 40) begin
      step(a);
      n++;
    end
    if (!a) chk("offer_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 40) begin
      idle(1);
      n++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_rd", out_rd, hold_rd);
        chk("hold_err", out_err, hold_e);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual data %0h expected no beat", out_data);
        end else begin
          mb = expq.pop_front();
          chk("out_data", out_data, mb.data);
          chk("out_rd", out_rd, mb.rd);
          chk("out_err", out_err, mb.err);
          pops++;
        end
      end
      chk("sel_err", sel_err, exp_sel_err);
      hold_prev = out_valid && !out_ready;
      hold_d = out_data;
      hold_rd = out_rd;
      hold_e = out_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   p0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    sel = '0;
    rd_in = '0;
    rand_srcs();
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_sel_err", sel_err, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    src_w[5] = 32'h1234_5678;
    pack_srcs();
    out_ready = 1'b1;
    offer(5, 9);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'h1234_5678);
    chk("lat_rd", out_rd, 9);
    chk("lat_err", out_err, 0);

    offer(8, 3);
    chk("const_data", out_data, 227);
    offer(12, 4);
    chk("illegal_data", out_data, 0);
    chk("illegal_err", out_err, 1);
    chk("illegal_sel_err", sel_err, 1);
    idle(3);
    chk("sticky_sel_err", sel_err, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("clr_sel_err", sel_err, 0);
    offer(13, 1);
    err_clr = 1'b1;
    offer(15, 2);
    err_clr = 1'b0;
    chk("set_wins_sel_err", sel_err, 1);
    drain();

    rand_srcs();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel = SEL_W'(i);
      rd_in = RD_W'(i + 10);
      if (i == 0) p0 = pops;
      step(a);
      chk("burst_accept", a, 1);
    end
    in_valid = 1'b0;
    idle(1);
    chk("burst_pops", pops - p0, 6);

    out_ready = 1'b0;
    offer(1, 21);
    offer(2, 22);
    in_valid = 1'b1;
    sel = 3;
    rd_in = 23;
    step(a);
    chk("full_no_accept", a, 0);
    chk("full_in_ready", in_ready, 0);
    chk("full_depth", expq.size(), 2);
    idle(2);
    out_ready = 1'b1;
    offer(3, 23);
    drain();

    out_ready = 1'b0;
    offer(14, 7);
    offer(6, 8);
    chk("pre_rst_sel_err", sel_err, 1);
    reset_n = 1'b0;
    idle(1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_sel_err", sel_err, 0);
    reset_n = 1'b1;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;
    idle(3);

    for (int c = 0; c < 1000; c++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      sel = SEL_W'($urandom_range(15));
      rd_in = RD_W'($urandom);
      err_clr = ($urandom_range(15) == 0);
      rand_srcs();
      step(a);
    end
    err_clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_wb_pipe.md
Name: mux_wb_pipe

Overview:
Parametrised write-back source selector for the multicycle datapath, following on from the fixed 9-way memtoreg mux. It selects one of NUM_SRC flattened data sources, or a built-in constant, and carries the destination register index alongside. The selected beat is registered into a 2-entry skid buffer with a valid/ready handshake, so the register-file write port can stall without losing data. Unencoded select values have defined behaviour and raise a sticky error flag.

Parameters:
WIDTH, 32, data width of each source and of the output
NUM_SRC, 8, number of data sources on src_bus
SEL_W, 4, select width; must satisfy 2**SEL_W > NUM_SRC
RD_W, 5, destination register index width
CONST_VAL, 227, value driven when sel == NUM_SRC (exception/trap constant)

Ports:
clk  input  1  clock, all state changes on its rising edge
reset_n  input  1  synchronous, active-low reset
in_valid  input  1  upstream beat present
in_ready  output  1  block can accept a beat this cycle
sel  input  SEL_W  source select for the current beat
src_bus  input  NUM_SRC*WIDTH  source k occupies bits [k*WIDTH +: WIDTH]
rd_in  input  RD_W  destination register for the current beat
out_valid  output  1  output beat present
out_ready  input  1  downstream (register-file write) accepts the beat
out_data  output  WIDTH  selected data
out_rd  output  RD_W  destination register of the output beat
out_err  output  1  current output beat had an illegal select
sel_err  output  1  sticky illegal-select flag
err_clr  input  1  clears sel_err

Behaviour:
- Select decode (combinational): sel < NUM_SRC gives source sel; sel == NUM_SRC gives CONST_VAL, zero-extended or truncated to WIDTH; sel > NUM_SRC is illegal and gives data 0 with the beat's err bit = 1. No latches; every sel value is defined.
- Accept = in_valid & in_ready. A beat captures {data, rd_in, err} from that same cycle's sel, src_bus and rd_in. Sources are not sampled again later.
- Storage states: EMPTY (out_valid=0), ONE (out reg only), FULL (out reg plus skid reg).
- in_ready = ~skid_valid, taken from a register. in_ready is 0 while reset_n = 0.
- Output moves when out_valid & out_ready.
- EMPTY: accept loads the out reg, and out_valid=1 next cycle. Latency is 1 cycle.
- ONE with output move and accept: out reg loads the new beat; stays in ONE. Throughput is 1 beat per cycle.
- ONE with no move and accept: beat goes to the skid reg; state becomes FULL and in_ready=0 next cycle.
- ONE with move and no accept: state becomes EMPTY.
- FULL with move: skid moves to the out reg; state becomes ONE and in_ready=1 next cycle. No accept can happen in FULL.
- Beat order is always preserved, and no beat is duplicated or dropped.
- Holding rule: out_data, out_rd and out_err stay stable while out_valid=1 and out_ready=0.
- sel_err is set on any accepted illegal beat and cleared by err_clr.
- If err_clr and an illegal accept happen in the same cycle, set wins and sel_err = 1.
- Reset (reset_n=0 at a clock edge): out_valid=0, skid empty, out_data=0, out_rd=0, out_err=0, sel_err=0. Reset mid-transfer discards all stored beats.
- in_valid=0 has no effect; out_ready while out_valid=0 has no effect.

Test Plan:
- Reset, then sel=5 with src5=0x1234_5678, rd_in=9, out_ready=1 -> next cycle out_valid=1, out_data=0x12345678, out_rd=9, out_err=0.
- sel=8 (== NUM_SRC) -> out_data=227 (0x000000E3); sel=12 -> out_data=0, out_err=1, sel_err=1 and stays 1 until err_clr; err_clr in the same cycle as another illegal beat -> sel_err stays 1.
- Back-to-back stream of 6 beats with sel=0..5, out_ready=1 throughout -> 6 outputs on consecutive cycles, in order, in_ready never drops.
- out_ready=0 and 3 beats offered (A,B,C) -> A in the out reg, B in the skid, in_ready=0, C held upstream. Raise out_ready -> outputs A,B,C in order with no loss.
- Stall with FULL, assert reset_n=0 for 1 cycle -> out_valid=0, in_ready=0 during reset and 1 after, sel_err=0, old beats never appear.
- Randomised in_valid/out_ready for 1000 cycles against a scoreboard -> exact order and contents match, and outputs stay stable while stalled.
